pc_block_reg: RTL and testbench

Program counter register for the multi-cycle RISC-V datapath. It holds the address of the instruction being fetched or executed, and loads a new address only when the control FSM asserts `PC_Update` (the PCWrite enable). It sits between the next-PC mux (ALU result, branch target or PC+4) and the instruction-memory address port. It also provides the previous PC and PC+4 to the datapath.

---
 rtl/pc_block_reg.sv | 46 ++++
 tb/tb_pc_block_reg.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_block_reg.sv
// Program counter register for the multi-cycle datapath: holds the fetch PC,
// remembers the PC before the last load, and exposes PC+4 and an alignment flag.
module pc_block_reg #(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Update,
    input  logic [WIDTH-1:0] next_addr,
    output logic [WIDTH-1:0] curr_addr,
    output logic [WIDTH-1:0] prev_addr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned
);

    logic [WIDTH-1:0] curr_q, curr_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    // next_addr only reaches the registers through the enabled path, so an
    // unknown value on it is harmless while PC_Update is low.
    always_comb begin
        curr_d = curr_q;
        prev_d = prev_q;
        if (PC_Update) begin
            prev_d = curr_q;
            curr_d = next_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curr_q <= RESET_ADDR;
            prev_q <= RESET_ADDR;
        end else begin
            curr_q <= curr_d;
            prev_q <= prev_d;
        end
    end

    assign curr_addr  = curr_q;
    assign prev_addr  = prev_q;
    assign pc_plus4   = curr_q + WIDTH'(4);
    assign misaligned = (curr_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_block_reg.sv
// Directed and random checks of pc_block_reg against a load-history model.
module tb_pc_block_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         PC_Update;
    logic [W-1:0] next_addr;
    logic [W-1:0] curr_addr, prev_addr, pc_plus4;
    logic         misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: every value the PC has held since reset, oldest first.
    logic [W-1:0] hist[$];

    pc_block_reg #(.WIDTH(W), .RESET_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .PC_Update (PC_Update),
        .next_addr (next_addr),
        .curr_addr (curr_addr),
        .prev_addr (prev_addr),
        .pc_plus4  (pc_plus4),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input logic r, input logic u, input logic [W-1:0] a);
        if (r) begin
            hist.delete();
            hist.push_back(32'h0);
            hist.push_back(32'h0);
        end else if (u) begin
            hist.push_back(a);
        end
    endfunction

    task automatic check_all(input string tag);
        logic [W-1:0] c, p;
        c = hist[hist.size()-1];
        p = hist[hist.size()-2];
        chk({tag, ".curr"}, curr_addr, c);
        chk({tag, ".prev"}, prev_addr, p);
        chk({tag, ".plus4"}, pc_plus4, W'((64'(c) + 64'd4) % 64'h1_0000_0000));
        chk({tag, ".misal"}, {31'd0, misaligned}, {31'd0, (c % 4) != 0});
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic u, input logic [W-1:0] a, input string tag);
        rst = r; PC_Update = u; next_addr = a;
        @(posedge clk);
        model_edge(r, u, a);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; PC_Update = 1'b0; next_addr = 'x;
        @(negedge clk);

        step(1'b1, 1'b0, 'x, "reset");
        chk("reset.plus4_const", pc_plus4, 32'd4);
        step(1'b0, 1'b1, 32'h4444, "load");
        chk("load.curr_const", curr_addr, 32'd17476);
        step(1'b0, 1'b0, 32'h5555, "hold1");
        step(1'b0, 1'b0, 32'h5555, "hold2");
        chk("hold.curr_const", curr_addr, 32'h4444);
        step(1'b1, 1'b1, 32'h1234, "rst_prio");
        step(1'b0, 1'b1, 32'hFFFF_FFFC, "wrap");
        chk("wrap.plus4_const", pc_plus4, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0006, "misal");
        chk("misal.prev_const", prev_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 32'h10, "b2b0");
        step(1'b0, 1'b1, 32'h14, "b2b1");
        step(1'b0, 1'b1, 32'h18, "b2b2");
        chk("b2b.prev_const", prev_addr, 32'h14);
        step(1'b0, 1'b1, 32'h18, "same1");
        chk("same.prev_const", prev_addr, 32'h18);

        // Enable pulse that falls before the edge must not load.
        @(negedge clk);
        PC_Update = 1'b1; next_addr = 32'hDEAD_BEEC;
        #2;
        PC_Update = 1'b0;
        step(1'b0, 1'b0, 32'hDEAD_BEEC, "glitch");

        for (int i = 0; i < 300; i++) begin
            logic r, u;
            logic [W-1:0] a;
            r = ($urandom_range(0, 19) == 0);
            u = ($urandom_range(0, 2) != 0);
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = {a[W-1:2], 2'b00};
            step(r, u, a, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
